mac_unit_vert_seq: RTL and testbench
====================================

// Module: mac_unit_vert_seq
// PURPOSE
//  Self-sequencing bit-serial (vertical) dot-product MAC: computes sum_i act[i]*w[i] by consuming one
//  weight bit-column per beat (LSB first) over a runtime precision of 1..MAX_WPREC bits.
//  Latches the activation vector once per operation, computes group sums internally, supports
//  per-group complement (skip-zero) columns, signed/unsigned weights and valid/ready handshakes.
//  Sits between the weight-column scheduler and the output/partial-sum buffer of a PE row.
// PARAMETERS
//  DATA_WIDTH    8    activation width (signed)
//  VEC_LENGTH    32   lanes per dot product; multiple of GROUP_SIZE
//  GROUP_SIZE    8    lanes per complement group; NGROUP = VEC_LENGTH/GROUP_SIZE
//  MAX_WPREC     8    max weight precision (columns per op); WP_W = $clog2(MAX_WPREC+1)
//  SUM_ACT_WIDTH DATA_WIDTH+$clog2(GROUP_SIZE)       signed group-sum width
//  ACC_WIDTH     DATA_WIDTH+MAX_WPREC+$clog2(VEC_LENGTH)  accumulator width
//  RESULT_WIDTH  2*DATA_WIDTH  width of result_hi
// PORTS
//  clk         in   1                      clock
//  reset       in   1                      synchronous, active-high
//  start_valid in   1                      op request
//  start_ready out  1                      high only in IDLE
//  w_prec      in   WP_W                   columns in this op, sampled at start
//  w_signed    in   1                      1: last column is sign column (negated)
//  load_accum  in   1                      1: init accumulator with accum_prev, else 0
//  accum_prev  in   ACC_WIDTH              signed initial partial sum
//  act_in      in   DATA_WIDTH x VEC_LENGTH signed activations, latched at start
//  col_valid   in   1                      column beat valid
//  col_ready   out  1                      high only in RUN
//  col_mask    in   VEC_LENGTH             weight bits of current column (or zero-bit mask if inverted)
//  col_inv     in   NGROUP                 per group: mask marks zero bits
//  out_valid   out  1                      result valid (DONE)
//  out_ready   in   1                      result accepted
//  result      out  ACC_WIDTH              signed final accumulator
//  result_hi   out  RESULT_WIDTH           result[ACC_WIDTH-1 -: RESULT_WIDTH]
//  busy        out  1                      state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, act regs=0, group sums=0, col_idx=0, p1_vld=0, out_valid=0.
//  FSM IDLE->RUN on start_valid&&start_ready: latch act_in, w_prec (0 or >MAX_WPREC -> MAX_WPREC),
//    w_signed; acc <= load_accum ? accum_prev : 0; gsum[g] <= sum of act in group g; col_idx <= 0.
//  RUN: beat accepted when col_valid&&col_ready. Group psum[g] = col_inv[g] ? gsum[g] - sum(act where
//    mask=1) : sum(act where mask=1). total = sum_g psum[g] (sign-extended, no overflow at params).
//    If col_idx==w_prec-1 && w_signed: total negated (two's complement). Shift left by col_idx,
//    sign-extend to ACC_WIDTH -> stage-1 reg p1 with p1_vld<=1; no beat -> p1_vld<=0. col_idx++.
//  Stage 2: acc <= acc + p1 when p1_vld (wraps mod 2^ACC_WIDTH; no saturation).
//  Last beat (col_idx==w_prec-1) accepted in cycle L: RUN->DRAIN end of L; DRAIN->DONE end of L+1;
//    out_valid=1 from cycle L+2, result stable while DONE.
//  DONE->IDLE on out_valid&&out_ready; start_ready rises next cycle (no same-cycle restart).
//  col_valid bubbles in RUN only stall; result independent of bubble pattern.
//  col_valid outside RUN ignored; start_valid outside IDLE ignored; inputs not re-sampled mid-op.
//  Reset mid-op: aborts immediately to reset state; no out_valid for the aborted op.
// TESTING
//  1 acts all 1, w_prec=8, w_signed=1, 8 beats mask=all-1, inv=0, init 0 -> result=-32, result_hi=0xFFFF.
//  2 acts all 3, w_prec=4 unsigned, lane0 bits 0b0101 (others 0), load_accum=1, accum_prev=100 -> 115.
//  3 group0 acts 1..8, rest 0; w_prec=1, col_inv[0]=1, mask=0 -> 36; mask lane0=1 -> 35.
//  4 repeat 1 with col_valid toggling every other cycle -> -32; out_valid exactly 2 cycles after last beat.
//  5 out_ready low 5 cycles in DONE -> result held, start_ready=0, col_ready=0; accept -> IDLE, start_ready=1.
//  6 reset after 3 beats of case 1 -> next cycle IDLE, out_valid=0, result=0; fresh case 2 -> 115.

Source files
------------

// File: rtl/mac_unit_vert_seq_if.sv
// mac_unit_vert_seq_if: start/column/result handshake bundle between the column scheduler and the MAC.
interface mac_unit_vert_seq_if #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 32,
    parameter int GROUP_SIZE = 8,
    parameter int MAX_WPREC  = 8
);
    localparam int NGROUP       = VEC_LENGTH / GROUP_SIZE;
    localparam int WP_W         = $clog2(MAX_WPREC + 1);
    localparam int ACC_WIDTH    = DATA_WIDTH + MAX_WPREC + $clog2(VEC_LENGTH);
    localparam int RESULT_WIDTH = 2 * DATA_WIDTH;

    logic                                   start_valid;
    logic                                   start_ready;
    logic [WP_W-1:0]                        w_prec;
    logic                                   w_signed;
    logic                                   load_accum;
    logic [ACC_WIDTH-1:0]                   accum_prev;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  act_in;
    logic                                   col_valid;
    logic                                   col_ready;
    logic [VEC_LENGTH-1:0]                  col_mask;
    logic [NGROUP-1:0]                      col_inv;
    logic                                   out_valid;
    logic                                   out_ready;
    logic [ACC_WIDTH-1:0]                   result;
    logic [RESULT_WIDTH-1:0]                result_hi;
    logic                                   busy;

    modport master (
        output start_valid, w_prec, w_signed, load_accum, accum_prev, act_in,
               col_valid, col_mask, col_inv, out_ready,
        input  start_ready, col_ready, out_valid, result, result_hi, busy
    );

    modport slave (
        input  start_valid, w_prec, w_signed, load_accum, accum_prev, act_in,
               col_valid, col_mask, col_inv, out_ready,
        output start_ready, col_ready, out_valid, result, result_hi, busy
    );
endinterface

// File: rtl/mac_unit_vert_seq.sv
// mac_unit_vert_seq: bit-serial dot-product MAC, one weight column per beat, LSB first.
module mac_unit_vert_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int VEC_LENGTH = 32,
    parameter int GROUP_SIZE = 8,
    parameter int MAX_WPREC  = 8
) (
    input logic               clk,
    input logic               reset,
    mac_unit_vert_seq_if.slave bus
);
    localparam int NGROUP        = VEC_LENGTH / GROUP_SIZE;
    localparam int WP_W          = $clog2(MAX_WPREC + 1);
    localparam int SUM_ACT_WIDTH = DATA_WIDTH + $clog2(GROUP_SIZE);
    localparam int ACC_WIDTH     = DATA_WIDTH + MAX_WPREC + $clog2(VEC_LENGTH);
    localparam int RESULT_WIDTH  = 2 * DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                                    state_q, state_d;
    logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]     act_r;
    logic [NGROUP-1:0][SUM_ACT_WIDTH-1:0]      gsum, gsum_in;
    logic [SUM_ACT_WIDTH-1:0]                  msum, psum;
    logic [ACC_WIDTH-1:0]                      acc, p1, total, term;
    logic [WP_W-1:0]                           w_prec_r, col_idx;
    logic                                      w_signed_r, p1_vld;
    logic                                      start, beat, last_col;

    assign start    = bus.start_valid && state_q == IDLE;
    assign beat     = bus.col_valid && state_q == RUN;
    assign last_col = col_idx == w_prec_r - WP_W'(1);

    always_comb begin
        gsum_in = '0;
        for (int g = 0; g < NGROUP; g++)
            for (int l = 0; l < GROUP_SIZE; l++)
                gsum_in[g] = gsum_in[g] + SUM_ACT_WIDTH'($signed(bus.act_in[g*GROUP_SIZE+l]));
    end

    // Inverted groups mark zero bits, so the ones-sum is the group total minus the marked lanes.
    always_comb begin
        total = '0;
        msum  = '0;
        psum  = '0;
        for (int g = 0; g < NGROUP; g++) begin
            msum = '0;
            for (int l = 0; l < GROUP_SIZE; l++)
                msum = msum + (bus.col_mask[g*GROUP_SIZE+l] ? SUM_ACT_WIDTH'($signed(act_r[g*GROUP_SIZE+l])) : '0);
            psum  = bus.col_inv[g] ? gsum[g] - msum : msum;
            total = total + ACC_WIDTH'($signed(psum));
        end
        term = ((w_signed_r && last_col) ? -total : total) << col_idx;
    end

    always_comb begin
        state_d = state_q == IDLE  ? (bus.start_valid ? RUN : IDLE) :
                  state_q == RUN   ? ((beat && last_col) ? DRAIN : RUN) :
                  state_q == DRAIN ? DONE :
                  (bus.out_ready ? IDLE : DONE);
        bus.start_ready = state_q == IDLE;
        bus.col_ready   = state_q == RUN;
        bus.out_valid   = state_q == DONE;
        bus.busy        = state_q != IDLE;
    end

    assign bus.result    = acc;
    assign bus.result_hi = acc[ACC_WIDTH-1 -: RESULT_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            acc        <= '0;
            act_r      <= '0;
            gsum       <= '0;
            col_idx    <= '0;
            p1         <= '0;
            p1_vld     <= 1'b0;
            w_prec_r   <= '0;
            w_signed_r <= 1'b0;
        end else begin
            state_q <= state_d;
            p1_vld  <= beat;
            if (beat) begin
                p1      <= term;
                col_idx <= col_idx + WP_W'(1);
            end
            if (start) begin
                act_r      <= bus.act_in;
                gsum       <= gsum_in;
                w_prec_r   <= (bus.w_prec == '0 || bus.w_prec > WP_W'(MAX_WPREC)) ? WP_W'(MAX_WPREC) : bus.w_prec;
                w_signed_r <= bus.w_signed;
                acc        <= bus.load_accum ? bus.accum_prev : '0;
                col_idx    <= '0;
            end else if (p1_vld) begin
                acc <= acc + p1;
            end
        end
    end
endmodule

// File: tb/tb_mac_unit_vert_seq.sv
// tb_mac_unit_vert_seq: scenario tasks driving ops through the interface; expected results queued in a scoreboard.
module tb_mac_unit_vert_seq;
    localparam int DW  = 8;
    localparam int VL  = 32;
    localparam int GS  = 8;
    localparam int MW  = 8;
    localparam int NG  = VL / GS;
    localparam int WPW = $clog2(MW + 1);
    localparam int AW  = DW + MW + $clog2(VL);

    typedef logic [VL-1:0][DW-1:0] acts_t;
    typedef logic [MW-1:0][VL-1:0] cols_t;
    typedef logic [MW-1:0][NG-1:0] invs_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mac_unit_vert_seq_if #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .GROUP_SIZE(GS), .MAX_WPREC(MW)) bus();
    mac_unit_vert_seq #(.DATA_WIDTH(DW), .VEC_LENGTH(VL), .GROUP_SIZE(GS), .MAX_WPREC(MW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [AW-1:0] sb[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [VL-1:0] expand(input logic [NG-1:0] iv);
        logic [VL-1:0] r;
        for (int g = 0; g < NG; g++)
            for (int l = 0; l < GS; l++)
                r[g*GS+l] = iv[g];
        return r;
    endfunction

    // Per-lane reference: rebuild each lane's weight from its bits, then a plain dot product.
    function automatic logic [AW-1:0] model(input acts_t a, input cols_t c, input int p,
                                            input bit sgn, input bit ld, input logic [AW-1:0] prev);
        longint s, w;
        logic [63:0] r;
        s = ld ? longint'($signed(prev)) : 64'sd0;
        for (int i = 0; i < VL; i++) begin
            w = 0;
            for (int b = 0; b < p; b++)
                if (c[b][i]) w += (sgn && b == p - 1) ? -(longint'(1) << b) : (longint'(1) << b);
            s += longint'($signed(a[i])) * w;
        end
        r = s;
        return r[AW-1:0];
    endfunction

    task automatic drive_op(input acts_t a, input cols_t c, input invs_t iv, input logic [WPW-1:0] wp,
                            input bit sgn, input bit ld, input logic [AW-1:0] prev, input bit bub,
                            input int stop_after);
        int beats, b, t;
        bit ph, acc_now;
        beats = (wp == 0 || wp > MW) ? MW : int'(wp);
        if (stop_after >= 0 && stop_after < beats) beats = stop_after;
        t = 0;
        while (!bus.start_ready && t < 100) begin step(); t++; end
        bus.act_in = a; bus.w_prec = wp; bus.w_signed = sgn; bus.load_accum = ld;
        bus.accum_prev = prev; bus.start_valid = 1'b1;
        step();
        bus.start_valid = 1'b0;
        for (int i = 0; i < VL; i++) bus.act_in[i] = DW'($urandom);
        bus.w_prec = WPW'($urandom); bus.w_signed = ~sgn; bus.accum_prev = AW'($urandom);
        b = 0; ph = 1'b0; t = 0;
        while (b < beats && t < 200) begin
            bus.col_valid = bub ? ph : 1'b1;
            ph = ~ph;
            bus.col_mask = c[b] ^ expand(iv[b]);
            bus.col_inv = iv[b];
            acc_now = bus.col_valid && bus.col_ready;
            step();
            if (acc_now) b++;
            t++;
        end
        bus.col_valid = 1'b0;
        bus.col_mask = VL'($urandom);
        bus.col_inv = NG'($urandom);
    endtask

    task automatic await_out(output bit ok);
        int t;
        t = 0;
        while (!bus.out_valid && t < 100) begin step(); t++; end
        ok = bus.out_valid;
    endtask

    task automatic accept();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else n_pass++;
        n_total++; if (bus.result !== '0) $display("FAIL reset_result: got %0h want 0", bus.result); else n_pass++;
        n_total++; if (bus.start_ready !== 1'b1) $display("FAIL reset_start_ready: got %b want 1", bus.start_ready); else n_pass++;
        n_total++; if (bus.col_ready !== 1'b0) $display("FAIL reset_col_ready: got %b want 0", bus.col_ready); else n_pass++;
    endtask

    task automatic test_signed_ones();
        acts_t a; cols_t c; invs_t iv; bit ok; logic [AW-1:0] exp;
        for (int i = 0; i < VL; i++) a[i] = DW'(1);
        c = '1; iv = '0;
        sb.push_back(-AW'(32));
        drive_op(a, c, iv, WPW'(8), 1'b1, 1'b0, '0, 1'b0, -1);
        await_out(ok);
        exp = sb.pop_front();
        n_total++; if (!ok || bus.result !== exp) $display("FAIL signed_ones: result=%0d want %0d", $signed(bus.result), $signed(exp)); else n_pass++;
        n_total++; if (bus.result_hi !== 16'hFFFF) $display("FAIL signed_ones_hi: result_hi=%h want ffff", bus.result_hi); else n_pass++;
        accept();
    endtask

    task automatic test_accum();
        acts_t a; cols_t c; invs_t iv; bit ok; logic [AW-1:0] exp;
        for (int i = 0; i < VL; i++) a[i] = DW'(3);
        c = '0; iv = '0;
        c[0][0] = 1'b1; c[2][0] = 1'b1;
        sb.push_back(AW'(115));
        drive_op(a, c, iv, WPW'(4), 1'b0, 1'b1, AW'(100), 1'b0, -1);
        await_out(ok);
        exp = sb.pop_front();
        n_total++; if (!ok || bus.result !== exp) $display("FAIL accum: result=%0d want %0d", $signed(bus.result), $signed(exp)); else n_pass++;
        accept();
    endtask

    task automatic test_inverted();
        acts_t a; cols_t c; invs_t iv; bit ok; logic [AW-1:0] exp;
        a = '0;
        for (int i = 0; i < GS; i++) a[i] = DW'(i + 1);
        c = '0; iv = '0;
        c[0][GS-1:0] = '1; iv[0] = NG'(1);
        sb.push_back(AW'(36));
        drive_op(a, c, iv, WPW'(1), 1'b0, 1'b0, '0, 1'b0, -1);
        await_out(ok);
        exp = sb.pop_front();
        n_total++; if (!ok || bus.result !== exp) $display("FAIL inv_all: result=%0d want %0d", $signed(bus.result), $signed(exp)); else n_pass++;
        accept();
        c[0][0] = 1'b0;
        sb.push_back(AW'(35));
        drive_op(a, c, iv, WPW'(1), 1'b0, 1'b0, '0, 1'b0, -1);
        await_out(ok);
        exp = sb.pop_front();
        n_total++; if (!ok || bus.result !== exp) $display("FAIL inv_lane0: result=%0d want %0d", $signed(bus.result), $signed(exp)); else n_pass++;
        accept();
    endtask

    task automatic test_bubbles();
        acts_t a; cols_t c; invs_t iv; bit ok; logic [AW-1:0] exp;
        for (int i = 0; i < VL; i++) a[i] = DW'(1);
        c = '1; iv = '0;
        sb.push_back(-AW'(32));
        drive_op(a, c, iv, WPW'(8), 1'b1, 1'b0, '0, 1'b1, -1);
        n_total++; if (bus.out_valid !== 1'b0) $display("FAIL bubbles_lat1: out_valid=%b want 0", bus.out_valid); else n_pass++;
        step();
        n_total++; if (bus.out_valid !== 1'b1) $display("FAIL bubbles_lat2: out_valid=%b want 1", bus.out_valid); else n_pass++;
        await_out(ok);
        exp = sb.pop_front();
        n_total++; if (!ok || bus.result !== exp) $display("FAIL bubbles: result=%0d want %0d", $signed(bus.result), $signed(exp)); else n_pass++;
        accept();
    endtask

    task automatic test_backpressure();
        acts_t a; cols_t c; invs_t iv; bit ok; logic [AW-1:0] exp;
        for (int i = 0; i < VL; i++) a[i] = DW'(3);
        c = '0; iv = '0;
        c[0][0] = 1'b1; c[2][0] = 1'b1;
        sb.push_back(AW'(115));
        drive_op(a, c, iv, WPW'(4), 1'b0, 1'b1, AW'(100), 1'b0, -1);
        await_out(ok);
        exp = sb.pop_front();
        bus.col_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            n_total++; if (!bus.out_valid || bus.result !== exp) $display("FAIL hold_result: cycle %0d result=%0d valid=%b want %0d", k, $signed(bus.result), bus.out_valid, $signed(exp)); else n_pass++;
            n_total++; if (bus.start_ready !== 1'b0 || bus.col_ready !== 1'b0) $display("FAIL hold_ready: cycle %0d start_ready=%b col_ready=%b want 0 0", k, bus.start_ready, bus.col_ready); else n_pass++;
            step();
        end
        bus.col_valid = 1'b0;
        n_total++; if (bus.result !== exp) $display("FAIL hold_final: result=%0d want %0d", $signed(bus.result), $signed(exp)); else n_pass++;
        bus.out_ready = 1'b1;
        #1;
        n_total++; if (bus.start_ready !== 1'b0) $display("FAIL accept_same_cycle: start_ready=%b want 0", bus.start_ready); else n_pass++;
        step();
        bus.out_ready = 1'b0;
        n_total++; if (bus.start_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0)
            $display("FAIL accept_idle: start_ready=%b busy=%b out_valid=%b want 1 0 0", bus.start_ready, bus.busy, bus.out_valid); else n_pass++;
    endtask

    task automatic test_reset_midop();
        acts_t a; cols_t c; invs_t iv; bit ok; logic [AW-1:0] exp;
        int seen;
        for (int i = 0; i < VL; i++) a[i] = DW'(1);
        c = '1; iv = '0;
        drive_op(a, c, iv, WPW'(8), 1'b1, 1'b0, '0, 1'b0, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_total++; if (bus.busy !== 1'b0 || bus.start_ready !== 1'b1) $display("FAIL abort_idle: busy=%b start_ready=%b want 0 1", bus.busy, bus.start_ready); else n_pass++;
        n_total++; if (bus.out_valid !== 1'b0 || bus.result !== '0) $display("FAIL abort_clear: out_valid=%b result=%0h want 0 0", bus.out_valid, bus.result); else n_pass++;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (bus.out_valid) seen++;
            step();
        end
        n_total++; if (seen != 0) $display("FAIL abort_no_out: out_valid cycles=%0d want 0", seen); else n_pass++;
        for (int i = 0; i < VL; i++) a[i] = DW'(3);
        c = '0;
        c[0][0] = 1'b1; c[2][0] = 1'b1;
        sb.push_back(AW'(115));
        drive_op(a, c, iv, WPW'(4), 1'b0, 1'b1, AW'(100), 1'b0, -1);
        await_out(ok);
        exp = sb.pop_front();
        n_total++; if (!ok || bus.result !== exp) $display("FAIL after_abort: result=%0d want %0d", $signed(bus.result), $signed(exp)); else n_pass++;
        accept();
    endtask

    task automatic test_back_to_back();
        acts_t a; cols_t c; invs_t iv; bit ok, sgn, ld, bub; logic [AW-1:0] exp, prev;
        logic [WPW-1:0] wp;
        int p;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < VL; i++) a[i] = DW'($urandom);
            for (int b = 0; b < MW; b++) begin
                c[b] = VL'($urandom);
                iv[b] = NG'($urandom);
            end
            wp = (n == 0) ? WPW'(0) : (n == 1) ? WPW'(12) : (n == 2) ? WPW'(1) : WPW'($urandom_range(1, MW));
            p = (wp == 0 || wp > MW) ? MW : int'(wp);
            sgn = 1'($urandom); ld = 1'($urandom); bub = 1'($urandom);
            prev = AW'($urandom);
            sb.push_back(model(a, c, p, sgn, ld, prev));
            drive_op(a, c, iv, wp, sgn, ld, prev, bub, -1);
            await_out(ok);
            exp = sb.pop_front();
            n_total++; if (!ok || bus.result !== exp) $display("FAIL b2b_op%0d: wp=%0d sgn=%b result=%0d want %0d", n, wp, sgn, $signed(bus.result), $signed(exp)); else n_pass++;
            accept();
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start_valid = 1'b0; bus.w_prec = '0; bus.w_signed = 1'b0; bus.load_accum = 1'b0;
        bus.accum_prev = '0; bus.act_in = '0; bus.col_valid = 1'b0; bus.col_mask = '0;
        bus.col_inv = '0; bus.out_ready = 1'b0;
        test_reset();
        test_signed_ones();
        test_accum();
        test_inverted();
        test_bubbles();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
